// File: rtl/baccarat_round_ctrl.sv
// Multi-round baccarat dealing controller: strobe sequencing, third-card tableau,
// latched result lights, saturating result tallies and optional auto-redeal.
module baccarat_round_ctrl #(
  parameter int unsigned TALLY_W     = 8,
  parameter bit          AUTO_REDEAL = 1'b0,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               start,
  input  logic               clear_tally,
  input  logic [3:0]         pscore,
  input  logic [3:0]         dscore,
  input  logic [3:0]         pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               busy,
  output logic               round_done,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
);

  localparam int unsigned        HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  typedef enum logic [2:0] {IDLE, P1, D1, P2, D2, P3, D3, RESULT} state_t;

  state_t              state, state_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
  logic [5:0]          load_nx;
  logic                pl_nx, dl_nx;
  logic [TALLY_W-1:0]  pw_nx, dw_nx, ti_nx;
  logic                banker_draws;

  // Banker third-card tableau once the player has drawn
  always_comb begin
    banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (pcard3 != 4'd8);
      4'd4:             banker_draws = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             banker_draws = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             banker_draws = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  // Next state, hold counter and next registered outputs
  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    pl_nx       = player_win_light;
    dl_nx       = dealer_win_light;
    pw_nx       = player_wins;
    dw_nx       = dealer_wins;
    ti_nx       = ties;

    case (state)
      IDLE: begin
        if (AUTO_REDEAL && (hold_cnt != HOLD_LAST))
          hold_cnt_nx = hold_cnt + HOLD_W'(1);
        if (start || (AUTO_REDEAL && (hold_cnt_nx == HOLD_LAST)))
          state_nx = P1;
      end
      P1: state_nx = D1;
      D1: state_nx = P2;
      P2: state_nx = D2;
      D2: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) state_nx = RESULT;
        else if (pscore <= 4'd5)                 state_nx = P3;
        else if (dscore <= 4'd5)                 state_nx = D3;
        else                                     state_nx = RESULT;
      end
      P3:     state_nx = banker_draws ? D3 : RESULT;
      D3:     state_nx = RESULT;
      RESULT: begin
        state_nx = IDLE;
        pl_nx    = (pscore >= dscore);
        dl_nx    = (dscore >= pscore);
        if (pscore > dscore) begin
          if (player_wins != TALLY_MAX) pw_nx = player_wins + TALLY_W'(1);
        end else if (dscore > pscore) begin
          if (dealer_wins != TALLY_MAX) dw_nx = dealer_wins + TALLY_W'(1);
        end else begin
          if (ties != TALLY_MAX) ti_nx = ties + TALLY_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state_nx == P1) begin
      hold_cnt_nx = '0;
      pl_nx       = 1'b0;
      dl_nx       = 1'b0;
    end

    if (clear_tally) begin
      pw_nx = '0;
      dw_nx = '0;
      ti_nx = '0;
    end

    load_nx = {state_nx == P1, state_nx == D1, state_nx == P2,
               state_nx == D2, state_nx == P3, state_nx == D3};
  end

  always_ff @(negedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      load_pcard1      <= 1'b0;
      load_dcard1      <= 1'b0;
      load_pcard2      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_pcard3      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      busy             <= 1'b0;
      round_done       <= 1'b0;
      player_wins      <= '0;
      dealer_wins      <= '0;
      ties             <= '0;
    end else begin
      state            <= state_nx;
      hold_cnt         <= hold_cnt_nx;
      {load_pcard1, load_dcard1, load_pcard2,
       load_dcard2, load_pcard3, load_dcard3} <= load_nx;
      player_win_light <= pl_nx;
      dealer_win_light <= dl_nx;
      busy             <= (state_nx != IDLE);
      round_done       <= (state_nx == RESULT);
      player_wins      <= pw_nx;
      dealer_wins      <= dw_nx;
      ties             <= ti_nx;
    end
  end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: a manual-start instance with 2-bit tallies and an
// auto-redeal instance, both checked every cycle against a round-level model.
module tb_baccarat_round_ctrl;

  localparam int unsigned TW_M = 2;
  localparam int unsigned TW_A = 8;
  localparam int unsigned HOLD = 4;

  typedef struct {
    logic [5:0] strb;
    logic       pl, dl, busy, done;
    int         pw, dw, ti;
  } exp_t;

  logic clk = 1'b1;
  logic rst_m, rst_a, start_m, start_a, clr_m, clr_a;
  logic [3:0] ps, ds, pc3;

  logic m_p1, m_p2, m_p3, m_d1, m_d2, m_d3, m_pl, m_dl, m_busy, m_done;
  logic [TW_M-1:0] m_pw, m_dw, m_ti;
  logic a_p1, a_p2, a_p3, a_d1, a_d2, a_d3, a_pl, a_dl, a_busy, a_done;
  logic [TW_A-1:0] a_pw, a_dw, a_ti;

  exp_t em, ea;
  bit   chk_en = 1'b0;
  int   n_cmp = 0, n_bad = 0, d3_seen = 0;

  always #5 clk = ~clk;

  baccarat_round_ctrl #(.TALLY_W(TW_M), .AUTO_REDEAL(1'b0), .HOLD_CYCLES(HOLD)) dut_m (
    .slow_clock(clk), .resetb(rst_m), .start(start_m), .clear_tally(clr_m),
    .pscore(ps), .dscore(ds), .pcard3(pc3),
    .load_pcard1(m_p1), .load_pcard2(m_p2), .load_pcard3(m_p3),
    .load_dcard1(m_d1), .load_dcard2(m_d2), .load_dcard3(m_d3),
    .player_win_light(m_pl), .dealer_win_light(m_dl), .busy(m_busy),
    .round_done(m_done), .player_wins(m_pw), .dealer_wins(m_dw), .ties(m_ti));

  baccarat_round_ctrl #(.TALLY_W(TW_A), .AUTO_REDEAL(1'b1), .HOLD_CYCLES(HOLD)) dut_a (
    .slow_clock(clk), .resetb(rst_a), .start(start_a), .clear_tally(clr_a),
    .pscore(ps), .dscore(ds), .pcard3(pc3),
    .load_pcard1(a_p1), .load_pcard2(a_p2), .load_pcard3(a_p3),
    .load_dcard1(a_d1), .load_dcard2(a_d2), .load_dcard3(a_d3),
    .player_win_light(a_pl), .dealer_win_light(a_dl), .busy(a_busy),
    .round_done(a_done), .player_wins(a_pw), .dealer_wins(a_dw), .ties(a_ti));

  function automatic exp_t zero_exp();
    exp_t e;
    e.strb = 6'b0; e.pl = 1'b0; e.dl = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    e.pw = 0; e.dw = 0; e.ti = 0;
    return e;
  endfunction

  function automatic logic [33:0] pack_exp(input exp_t e);
    return {e.strb, e.pl, e.dl, e.busy, e.done, 8'(e.pw), 8'(e.dw), 8'(e.ti)};
  endfunction

  function automatic bit banker_draws(input int d, input int p3);
    if (d <= 2) return 1'b1;
    if (d == 3) return p3 != 8;
    if (d == 4) return (p3 >= 2) && (p3 <= 7);
    if (d == 5) return (p3 >= 4) && (p3 <= 7);
    if (d == 6) return (p3 >= 6) && (p3 <= 7);
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_vec(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(posedge clk) begin
    if (chk_en) begin
      cmp_vec("dut_m", {m_p1, m_d1, m_p2, m_d2, m_p3, m_d3, m_pl, m_dl, m_busy, m_done,
                        8'(m_pw), 8'(m_dw), 8'(m_ti)}, pack_exp(em));
      cmp_vec("dut_a", {a_p1, a_d1, a_p2, a_d2, a_p3, a_d3, a_pl, a_dl, a_busy, a_done,
                        8'(a_pw), 8'(a_dw), 8'(a_ti)}, pack_exp(ea));
      if (m_d3) d3_seen++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One full round: cards dealt follow the tableau, result judged on (fp, fd)
  task automatic run_round(input bit a, input int p4, input int d4, input int pc,
                           input int dp3, input int fp, input int fd,
                           input bit clr_res, input bit abort_p3);
    int   path[$];
    exp_t e;
    int   tmax;
    path = '{0, 1, 2, 3};
    if (p4 >= 8 || d4 >= 8) path.push_back(6);
    else if (p4 <= 5) begin
      path.push_back(4);
      if (banker_draws(dp3, pc)) path.push_back(5);
      path.push_back(6);
    end else begin
      if (d4 <= 5) path.push_back(5);
      path.push_back(6);
    end

    if (a) repeat (HOLD - 1) tick();
    else start_m = 1'b1;

    foreach (path[i]) begin
      tick();
      e = a ? ea : em;
      e.strb = (path[i] < 6) ? (6'b100000 >> path[i]) : 6'b0;
      e.busy = 1'b1;
      e.done = (path[i] == 6);
      if (path[i] == 0) begin e.pl = 1'b0; e.dl = 1'b0; end
      if (a) ea = e; else em = e;
      ps = 4'($urandom_range(0, 9));
      ds = 4'($urandom_range(0, 9));
      pc3 = 4'($urandom_range(0, 9));
      start_m = a ? 1'b0 : 1'($urandom_range(0, 1));
      clr_m = 1'b0;
      clr_a = 1'b0;
      case (path[i])
        3: begin ps = 4'(p4); ds = 4'(d4); end
        4: begin
          ds = 4'(dp3);
          pc3 = 4'(pc);
          if (abort_p3 && !a) begin
            #2 rst_m = 1'b0;
            em = zero_exp();
            start_m = 1'b0;
            #1;
            chk("abort_strobes", int'({m_p1, m_d1, m_p2, m_d2, m_p3, m_d3}), 0);
            chk("abort_busy", int'(m_busy), 0);
            chk("abort_tallies", int'(m_pw) + int'(m_dw) + int'(m_ti), 0);
            return;
          end
        end
        6: begin
          ps = 4'(fp);
          ds = 4'(fd);
          if (a) clr_a = clr_res; else clr_m = clr_res;
        end
        default: ;
      endcase
    end

    tick();
    e = a ? ea : em;
    e.strb = 6'b0; e.busy = 1'b0; e.done = 1'b0;
    e.pl = (fp >= fd);
    e.dl = (fd >= fp);
    tmax = (1 << (a ? TW_A : TW_M)) - 1;
    if (clr_res) begin
      e.pw = 0; e.dw = 0; e.ti = 0;
    end else if (fp > fd) e.pw = (e.pw < tmax) ? e.pw + 1 : tmax;
    else if (fd > fp)     e.dw = (e.dw < tmax) ? e.dw + 1 : tmax;
    else                  e.ti = (e.ti < tmax) ? e.ti + 1 : tmax;
    if (a) ea = e; else em = e;
    start_m = 1'b0;
    clr_m = 1'b0;
    clr_a = 1'b0;
  endtask

  task automatic rnd_round(input bit a);
    run_round(a, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
              ($urandom_range(0, 15) == 0), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d3_before;
    rst_m = 1'b1; rst_a = 1'b1; start_m = 1'b0; start_a = 1'b0;
    clr_m = 1'b0; clr_a = 1'b0; ps = 4'd0; ds = 4'd0; pc3 = 4'd0;
    em = zero_exp(); ea = zero_exp();
    #1 rst_m = 1'b0; rst_a = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_busy", int'(m_busy), 0);
    chk("reset_tally", int'(m_pw), 0);
    tick();
    rst_m = 1'b1;

    // Natural: player 8 beats banker 5
    run_round(1'b0, 8, 5, 0, 0, 8, 5, 1'b0, 1'b0);
    chk("t1_plight", int'(m_pl), 1);
    chk("t1_dlight", int'(m_dl), 0);
    chk("t1_pwins", int'(m_pw), 1);

    // Player draws, banker 3 stands on an 8, draws on a 9
    d3_before = d3_seen;
    run_round(1'b0, 3, 3, 8, 3, 1, 3, 1'b0, 1'b0);
    chk("t2a_no_d3", d3_seen - d3_before, 0);
    chk("t2a_dwins", int'(m_dw), 1);
    chk("t2a_dlight", int'(m_dl), 1);
    d3_before = d3_seen;
    run_round(1'b0, 3, 3, 9, 3, 1, 3, 1'b0, 1'b0);
    chk("t2b_d3", d3_seen - d3_before, 1);

    // Player stands on 7, banker 4 draws directly
    d3_before = d3_seen;
    run_round(1'b0, 7, 4, 0, 4, 7, 7, 1'b0, 1'b0);
    chk("t3_d3", d3_seen - d3_before, 1);
    chk("t3_ties", int'(m_ti), 1);
    chk("t3_lights", int'({m_pl, m_dl}), 3);

    // Saturation of the 2-bit tally, then clear colliding with RESULT
    repeat (3) run_round(1'b0, 9, 0, 0, 0, 9, 0, 1'b0, 1'b0);
    chk("t4_sat", int'(m_pw), 3);
    run_round(1'b0, 9, 0, 0, 0, 9, 0, 1'b1, 1'b0);
    chk("t4_clear", int'(m_pw) + int'(m_dw) + int'(m_ti), 0);

    for (int k = 0; k < 60; k++) begin
      rnd_round(1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Build up tallies, then drop reset in P3
    run_round(1'b0, 6, 6, 0, 6, 6, 2, 1'b0, 1'b0);
    run_round(1'b0, 2, 5, 3, 5, 0, 0, 1'b0, 1'b1);
    repeat (2) tick();
    rst_m = 1'b1;
    run_round(1'b0, 0, 9, 0, 9, 0, 9, 1'b0, 1'b0);
    chk("t6_dwins", int'(m_dw), 1);
    chk("t6_pwins", int'(m_pw), 0);

    // Auto-redeal instance
    rst_a = 1'b1;
    run_round(1'b1, 9, 2, 0, 2, 5, 2, 1'b0, 1'b0);
    chk("t5_plight", int'(a_pl), 1);
    chk("t5_pwins", int'(a_pw), 1);
    for (int k = 0; k < 25; k++) rnd_round(1'b1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/baccarat_round_ctrl.md
Name: baccarat_round_ctrl

Overview:
Parametrised, multi-round successor to the single-hand baccarat dealing controller. It sequences the card-load strobes for one hand per start request and applies the full player and banker third-card tableau. It latches the result lights and keeps saturating win/loss/tie tallies across rounds, with an optional auto-redeal mode. It sits between the card/score datapath (pscore, dscore, pcard3) and the board display.

Parameters:
TALLY_W, 8, width of each result tally counter (saturating).
AUTO_REDEAL, 0, 1 = start the next round automatically after HOLD_CYCLES idle cycles; 0 = wait for start.
HOLD_CYCLES, 4, number of idle cycles before auto-redeal; must be 1 or more; counter width is $clog2(HOLD_CYCLES+1).

Ports:
slow_clock  input  1  clock; all state updates occur on the falling edge, as in the existing dealing FSM.
resetb  input  1  reset, asynchronous, active-low.
start  input  1  request a new round; sampled only in IDLE.
clear_tally  input  1  synchronous clear of all three tallies.
pscore  input  4  player hand score, 0-9.
dscore  input  4  banker hand score, 0-9.
pcard3  input  4  baccarat value of player third card, 0-9.
load_pcard1, load_pcard2, load_pcard3  output  1 each  player card-register load strobes.
load_dcard1, load_dcard2, load_dcard3  output  1 each  banker card-register load strobes.
player_win_light, dealer_win_light  output  1 each  result lights; both high = tie.
busy  output  1  high in every state except IDLE.
round_done  output  1  one-cycle pulse while in RESULT.
player_wins, dealer_wins, ties  output  TALLY_W each  result tallies.

Behaviour:
- Reset (async, resetb=0):
  - state=IDLE.
  - All load strobes, lights, busy and round_done are 0.
  - Tallies are 0 and the hold counter is 0.
  - Reset mid-round abandons the hand immediately; no tally update occurs.
- All outputs are registered and change only on the falling edge (or on async reset).
- States: IDLE, P1, D1, P2, D2, P3, D3, RESULT.
- Strobes are one-hot. P1, D1, P2, D2, P3 and D3 each assert only their matching load strobe, for exactly one cycle.
- IDLE -> P1 when start=1, or when AUTO_REDEAL=1 and the hold counter reaches HOLD_CYCLES.
  - Entering P1 clears both lights and the hold counter.
  - start outside IDLE is ignored; no queuing.
- Fixed sequence: P1 -> D1 -> P2 -> D2.
- Leaving D2 (scores reflect four cards):
  - pscore>=8 or dscore>=8 -> RESULT (natural).
  - else pscore<=5 -> P3.
  - else (pscore 6/7) dscore<=5 -> D3, otherwise -> RESULT.
- Leaving P3 (pcard3 valid), banker draws (-> D3) when any of:
  - dscore<=2;
  - dscore=3 and pcard3!=8;
  - dscore=4 and pcard3 in 2..7;
  - dscore=5 and pcard3 in 4..7;
  - dscore=6 and pcard3 in 6..7.
  - Otherwise -> RESULT; dscore=7 always -> RESULT.
- D3 -> RESULT unconditionally.
- RESULT (one cycle):
  - Compare the final scores. pscore>dscore: player light=1 and player_wins+1. dscore>pscore: dealer light=1 and dealer_wins+1. Equal: both lights=1 and ties+1.
  - round_done=1.
  - Next state is IDLE.
- Lights hold their value through IDLE until the next P1.
- Tallies saturate at 2^TALLY_W-1; no wrap.
- clear_tally=1 zeroes all tallies and takes priority over a same-cycle RESULT increment.
- Hold counter runs only in IDLE when AUTO_REDEAL=1 and saturates at HOLD_CYCLES. With AUTO_REDEAL=0 the counter stays 0.
- Latency from start (sampled at edge n) to the final strobe and RESULT:
  - load_pcard1 is high for edge n to n+1.
  - Natural hand: RESULT at edge n+4.
  - Player-only or banker-only third card: RESULT at edge n+5.
  - Both third cards: RESULT at edge n+6.
- Score inputs above 9 are illegal; behaviour for them is unspecified, but the FSM must never leave the legal state set.

Test Plan:
1. Reset, start pulse; pscore=8, dscore=5 at D2 -> strobes P1,D1,P2,D2 then RESULT at edge n+4; player_win_light=1, player_wins=1, round_done pulses once.
2. pscore=3 at D2, pcard3=8, dscore=3 at P3 -> P3 visited, D3 skipped; with dscore final 3 and pscore final 1, dealer_wins=1 and dealer_win_light=1. Repeat with pcard3=9 -> D3 visited.
3. pscore=7, dscore=4 at D2 -> D3 directly (no P3); final 7 vs 7 -> both lights=1, ties=1.
4. TALLY_W=2: four player wins -> player_wins stays 3. Assert clear_tally in the same cycle as RESULT -> all tallies 0.
5. AUTO_REDEAL=1, HOLD_CYCLES=4, start held low -> next P1 exactly 5 falling edges after RESULT; lights clear on entry to P1.
6. Drop resetb during P3 -> all outputs 0 immediately (async), tallies 0. Release reset and pulse start -> clean round from P1.
